// File: rtl/float_to_int_if.sv
// float_to_int_if -- streaming bus between a float producer and the converter.
//
// Signals:
//   in_valid   qualifies in for the current cycle
//   in         float word, {sign, exponent, mantissa} MSB to LSB
//   out_valid  qualifies out and overflow
//   out        two's-complement integer result
//   overflow   result saturated, or the input was Inf/NaN
//
// Modports:
//   master  the side that produces floats and consumes integer results
//   slave   the converter itself
interface float_to_int_if #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
);
  logic                                 in_valid;
  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] in;
  logic                                 out_valid;
  logic [INT_SIZE-1:0]                  out;
  logic                                 overflow;

  modport master (
    output in_valid, in,
    input  out_valid, out, overflow
  );

  modport slave (
    input  in_valid, in,
    output out_valid, out, overflow
  );
endinterface

// File: rtl/float_to_int.sv
// float_to_int -- pipelined float to signed-integer converter, truncating.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high; clears the valid pipeline and outputs
//   bus    float_to_int_if.slave: in_valid/in in, out_valid/out/overflow out
//
// An input sampled at edge N is visible on the outputs after edge N+3:
//   edge N   : input register captures in/in_valid
//   edge N+1 : stage 1 registers the decoded class and shift controls
//   edge N+2 : stage 2 registers the shifted magnitude and saturation flags
//   edge N+3 : stage 3 registers the signed/saturated result
// Every register is reset so the outputs never carry X after reset.
module float_to_int #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
) (
  input  logic           clk,
  input  logic           reset,
  float_to_int_if.slave  bus
);

  localparam int FW   = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
  localparam int BIAS = 2 ** (EXPONENT_SIZE - 1) - 1;
  localparam int SW   = $clog2(INT_SIZE) + 1;

  localparam logic [EXPONENT_SIZE:0] BIAS_V  = (EXPONENT_SIZE + 1)'(BIAS);
  localparam logic [INT_SIZE-1:0]    INT_MAX = {1'b0, {(INT_SIZE - 1){1'b1}}};
  localparam logic [INT_SIZE-1:0]    INT_MIN = {1'b1, {(INT_SIZE - 1){1'b0}}};

  // CLS_MIN_EXACT is the one big value that is representable: -2^(INT_SIZE-1).
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_MIN_EXACT,
    CLS_SAT,
    CLS_NAN
  } cls_t;

  // ---------------------------------------------------------------- valid path
  logic [2:0] valid_reg;
  logic       out_valid_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_valid
    logic valid_prev;
    if (gi == 0) begin : g_first
      assign valid_prev = bus.in_valid;
    end else begin : g_rest
      assign valid_prev = valid_reg[gi-1];
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) valid_reg[gi] <= 1'b0;
      else       valid_reg[gi] <= valid_prev;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_valid_reg <= 1'b0;
    else       out_valid_reg <= valid_reg[2];
  end

  // ----------------------------------------------------------- input register
  logic [FW-1:0] in_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_reg <= '0;
    else       in_reg <= bus.in;
  end

  // ------------------------------------------------------------ stage 1 decode
  logic                       dec_sign;
  logic [EXPONENT_SIZE-1:0]   dec_exp;
  logic [MANTISSA_SIZE-1:0]   dec_man;
  logic signed [EXPONENT_SIZE:0] e_unb;
  int                         e_int;
  cls_t                       dec_cls;
  logic                       dec_shl;
  logic [SW-1:0]              dec_sh;

  assign dec_sign = in_reg[FW-1];
  assign dec_exp  = in_reg[FW-2:MANTISSA_SIZE];
  assign dec_man  = in_reg[MANTISSA_SIZE-1:0];
  assign e_unb    = $signed({1'b0, dec_exp}) - $signed(BIAS_V);
  assign e_int    = int'(e_unb);

  // Only the normal class computes a shift, so the amount always lies in
  // 0..INT_SIZE-2 and fits SW bits; big/special never reach the shifter.
  always_comb begin
    dec_cls = CLS_NORMAL;
    dec_shl = 1'b0;
    dec_sh  = '0;
    if (dec_exp == '0) begin
      dec_cls = CLS_ZERO;                       // zero and denormals flush
    end else if (&dec_exp) begin
      dec_cls = (dec_man != '0) ? CLS_NAN : CLS_SAT;
    end else if (e_unb[EXPONENT_SIZE]) begin
      dec_cls = CLS_ZERO;                       // |x| < 1 truncates to 0
    end else if (e_int > INT_SIZE - 2) begin
      dec_cls = (dec_sign && e_int == INT_SIZE - 1 && dec_man == '0)
              ? CLS_MIN_EXACT : CLS_SAT;
    end else if (e_int >= MANTISSA_SIZE) begin
      dec_shl = 1'b1;
      dec_sh  = SW'(e_int - MANTISSA_SIZE);
    end else begin
      dec_sh  = SW'(MANTISSA_SIZE - e_int);
    end
  end

  cls_t                   s1_cls;
  logic                   s1_sign;
  logic                   s1_shl;
  logic [SW-1:0]          s1_sh;
  logic [MANTISSA_SIZE:0] s1_sig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_cls  <= CLS_ZERO;
      s1_sign <= 1'b0;
      s1_shl  <= 1'b0;
      s1_sh   <= '0;
      s1_sig  <= '0;
    end else begin
      s1_cls  <= dec_cls;
      s1_sign <= dec_sign;
      s1_shl  <= dec_shl;
      s1_sh   <= dec_sh;
      s1_sig  <= {1'b1, dec_man};
    end
  end

  // ------------------------------------------------------------- stage 2 shift
  logic [INT_SIZE-1:0] sig_ext;
  logic [INT_SIZE-1:0] shifted;

  assign sig_ext = {{(INT_SIZE - MANTISSA_SIZE - 1){1'b0}}, s1_sig};
  assign shifted = s1_shl ? (sig_ext << s1_sh) : (sig_ext >> s1_sh);

  logic [INT_SIZE-1:0] s2_mag;
  logic                s2_neg;
  logic                s2_sat;
  logic                s2_sat_neg;
  logic                s2_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_mag     <= '0;
      s2_neg     <= 1'b0;
      s2_sat     <= 1'b0;
      s2_sat_neg <= 1'b0;
      s2_ovf     <= 1'b0;
    end else begin
      s2_mag     <= (s1_cls == CLS_NORMAL) ? shifted : '0;
      s2_neg     <= s1_sign && (s1_cls == CLS_NORMAL);
      s2_sat     <= s1_cls inside {CLS_SAT, CLS_NAN, CLS_MIN_EXACT};
      s2_sat_neg <= s1_sign && (s1_cls != CLS_NAN);  // NaN is always +max
      s2_ovf     <= (s1_cls == CLS_SAT) || (s1_cls == CLS_NAN);
    end
  end

  // -------------------------------------------------------- stage 3 sign/sat
  logic [INT_SIZE-1:0] out_reg;
  logic                overflow_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (s2_sat)      out_reg <= s2_sat_neg ? INT_MIN : INT_MAX;
      else if (s2_neg) out_reg <= ~s2_mag + 1'b1;
      else             out_reg <= s2_mag;
      overflow_reg <= s2_ovf;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out       = out_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int -- self-checking bench for float_to_int at default sizes.
// Directed vectors carry hand-computed results; random vectors are checked
// against a real-arithmetic reference. Every cycle the output valid is
// compared with the input valid driven three edges earlier.
module tb_float_to_int;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  float_to_int_if #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32)) bus ();

  float_to_int #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          v;
    logic [31:0] f;
    logic [31:0] val;
    bit          ovf;
  } exp_t;

  exp_t hist[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value of the float as a real, then truncate or saturate.
  function automatic void ref_model(input logic [31:0] f, output logic [31:0] val,
                                    output bit ovf);
    bit  s;
    int  ex;
    int  mn;
    real r;
    s   = f[31];
    ex  = int'(f[30:23]);
    mn  = int'(f[22:0]);
    ovf = 1'b0;
    val = 32'h0;
    if (ex == 255) begin
      ovf = 1'b1;
      val = (mn != 0 || !s) ? 32'h7FFFFFFF : 32'h80000000;
    end else if (ex != 0) begin
      r = (1.0 + mn / 8388608.0) * (2.0 ** (ex - 127));
      if (s) r = -r;
      if (r >= 2147483648.0) begin
        val = 32'h7FFFFFFF;
        ovf = 1'b1;
      end else if (r < -2147483648.0) begin
        val = 32'h80000000;
        ovf = 1'b1;
      end else begin
        val = $rtoi(r);
      end
    end
  endfunction

  // Drive one cycle, then check whatever the pipeline should be emitting.
  task automatic step(input bit v, input logic [31:0] f, input logic [31:0] ev,
                      input bit eo);
    exp_t e;
    bus.in_valid = v;
    bus.in       = f;
    hist.push_back('{v: v, f: f, val: ev, ovf: eo});
    @(posedge clk);
    #1;
    if (hist.size() > 3) begin
      e = hist.pop_front();
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, e.v});
      if (e.v) begin
        check("out", bus.out, e.val);
        check("overflow", {31'b0, bus.overflow}, {31'b0, e.ovf});
        $display("txn in=%h out=%h overflow=%0b", e.f, bus.out, bus.overflow);
      end
    end
  endtask

  task automatic step_model(input bit v, input logic [31:0] f);
    logic [31:0] ev;
    bit          eo;
    ref_model(f, ev, eo);
    step(v, f, ev, eo);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'h0);
    check({tag, "_out"}, bus.out, 32'h0);
    check({tag, "_overflow"}, {31'b0, bus.overflow}, 32'h0);
  endtask

  localparam int ND = 14;
  logic [31:0] d_in  [ND] = '{32'h3F800000, 32'hC0200000, 32'h3F400000, 32'h4B7FFFFF,
                              32'h4F000000, 32'hCF000000, 32'hCF000001, 32'h7F800000,
                              32'hFF800000, 32'hFFC00000, 32'h00000001, 32'h80000000,
                              32'hBF000000, 32'h4EFFFFFF};
  logic [31:0] d_out [ND] = '{32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'h00FFFFFF,
                              32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
                              32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000,
                              32'h00000000, 32'h7FFFFF80};
  bit          d_ovf [ND] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    logic [31:0] f;
    int          sent;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 32'h0;
    #1;
    check_cleared("reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Lone 1.0 surrounded by idle cycles: out_valid must pulse exactly once.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, d_in[0], d_out[0], d_ovf[0]);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0);

    // Remaining directed vectors back to back.
    for (int i = 1; i < ND; i++) step(1'b1, d_in[i], d_out[i], d_ovf[i]);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0);

    // 100 random valid inputs with random gaps.
    sent = 0;
    while (sent < 100) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, $urandom, 32'h0, 1'b0);
      end else begin
        f = $urandom;
        if ($urandom_range(0, 4) != 0) f[30:23] = 8'($urandom_range(110, 162));
        step_model(1'b1, f);
        sent++;
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset with B and C still in flight, just after A has emerged.
    step(1'b1, 32'h3F800000, 32'd1, 1'b0);
    step(1'b1, 32'h40000000, 32'd2, 1'b0);
    step(1'b1, 32'h40400000, 32'd3, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_cleared("midreset");
    hist.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    check_cleared("held_reset");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b0);

    // Pipeline still works after the mid-flight reset.
    step(1'b1, 32'hC0200000, 32'hFFFFFFFE, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
